score_digit_scheduler: RTL

- Converts a binary score into NUM_DIGITS decimal digits with a sequential double-dabble.
- Commits the digits to a display register only during vertical blanking, so the screen never tears.
- Time-shares one numbers-sprite instance across all digit positions by driving its number and x position from hcount_in.
- Sits between game logic (score source) and the 1-bit numbers sprite ROM renderer.

---
 rtl/score_digit_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/score_digit_scheduler.sv
// Binary score to decimal digits via sequential double-dabble, committed during vertical
// blanking, plus a registered slot decoder that time-shares one numbers sprite across all digits.
module score_digit_scheduler #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCORE_WIDTH = 14,
    parameter int X0          = 100,
    parameter int PITCH       = 32,
    parameter int COMMIT_LINE = 720,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    pixel_clk_in,
    input  logic                    rst_in,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic [SCORE_WIDTH-1:0]  score_in,
    input  logic                    score_valid_in,
    output logic                    score_ready_out,
    output logic [3:0]              number_out,
    output logic [10:0]             x_out,
    output logic                    blank_out,
    output logic [4*NUM_DIGITS-1:0] digits_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_SCORE = pow10(NUM_DIGITS) - 1;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD
    } state_t;

    state_t                         state;
    logic [SCORE_WIDTH-1:0]         bin_q;
    logic [BCD_W-1:0]               bcd_q;
    logic [BCD_W-1:0]               pending_q;
    logic [CNT_W-1:0]               cnt_q;

    logic [BCD_W-1:0]               bcd_adj;
    logic [BCD_W+SCORE_WIDTH-1:0]   shifted;
    logic [SCORE_WIDTH-1:0]         score_sat;
    logic                           transfer;
    logic                           commit;

    assign transfer = score_valid_in && score_ready_out;
    assign commit   = (hcount_in == 11'd0) && (vcount_in == 10'(COMMIT_LINE));

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Scores past the displayable range saturate to all nines.
    always_comb begin
        score_sat = score_in;
        if (64'(score_in) > MAX_SCORE) score_sat = SCORE_WIDTH'(MAX_SCORE);
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            score_ready_out <= 1'b0;
            bin_q           <= '0;
            bcd_q           <= '0;
            pending_q       <= '0;
            cnt_q           <= '0;
            digits_out      <= '0;
        end else begin
            score_ready_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        bin_q <= score_sat;
                        bcd_q <= '0;
                        cnt_q <= CNT_W'(SCORE_WIDTH);
                        state <= CONVERT;
                    end else begin
                        score_ready_out <= 1'b1;
                    end
                end
                CONVERT: begin
                    bcd_q <= shifted[BCD_W+SCORE_WIDTH-1 -: BCD_W];
                    bin_q <= shifted[SCORE_WIDTH-1:0];
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        pending_q <= shifted[BCD_W+SCORE_WIDTH-1 -: BCD_W];
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (commit) begin
                        digits_out <= pending_q;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic        slot_hit;
    logic [3:0]  slot_num;
    logic [10:0] slot_x;
    logic        slot_lz;
    logic [3:0]  digit;
    logic        zero_run;

    // Comparator chain over slot windows; zero_run tracks whether digits 0..k are all zero.
    always_comb begin
        slot_hit = 1'b0;
        slot_num = 4'd0;
        slot_x   = 11'(X0);
        slot_lz  = 1'b0;
        digit    = 4'd0;
        zero_run = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit    = digits_out[4*(NUM_DIGITS-1-k) +: 4];
            zero_run = zero_run && (digit == 4'd0);
            if (int'(hcount_in) >= X0 + k*PITCH && int'(hcount_in) < X0 + (k+1)*PITCH) begin
                slot_hit = 1'b1;
                slot_num = digit;
                slot_x   = 11'(X0 + k*PITCH);
                slot_lz  = (LZ_BLANK != 0) && (k < NUM_DIGITS-1) && zero_run;
            end
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            number_out <= 4'd0;
            x_out      <= 11'(X0);
            blank_out  <= 1'b1;
        end else begin
            number_out <= slot_num;
            x_out      <= slot_x;
            blank_out  <= !slot_hit || slot_lz;
        end
    end

endmodule
